chargen_src: RTL and testbench
==============================

Name: chargen_src

Overview:
- Source stage ahead of the chargen FIFO. Generates the classic chargen rotating ASCII pattern: fixed-length lines of printable characters, each terminated by CR LF.
- Each line starts one character later than the previous one.
- Bytes leave on a valid/ready handshake into the FIFO write side.
- An optional cycle divider paces output, using the same counting scheme as the board's LED divider.

Parameters:
- LINE_LEN, 72, printable characters per line before CR LF (legal range 1..255)
- FIRST_CHAR, 8'h20, lowest character in the rotation
- LAST_CHAR, 8'h7E, highest character in the rotation (must be > FIRST_CHAR)
- CDIV, 0, pacing. 0 or 1 = back-to-back bytes. N>1 = minimum N cycles between consecutive handshakes.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- en  input  1  generation enable
- data  output  8  current byte
- valid  output  1  data holds a byte for the consumer
- ready  input  1  consumer (FIFO write side) accepts byte
- line_cnt  output  16  completed lines, wraps at 16'hFFFF
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset and clock: n_rst is asynchronous, active-low; clk is the clock. All state is registered on posedge clk.
- Reset values: data=FIRST_CHAR, valid=0, line_cnt=0, busy=0, state=IDLE, line_start=FIRST_CHAR, char_idx=0, pace_cnt=0.
- Handshake:
  - A transfer occurs in any cycle where valid && ready.
  - Once valid is high, data and valid stay stable until the transfer. valid never drops without a transfer; en does not override this.
  - valid does not depend combinationally on ready.
- States:
  - IDLE: valid=0. Moves to CHAR when en=1; valid rises the next cycle.
  - CHAR:
    - Outputs cur_char.
    - On transfer: char_idx++ and cur_char advances.
    - If char_idx was LINE_LEN-1, go to CR instead.
  - CR: outputs 8'h0D. On transfer, go to LF.
  - LF: outputs 8'h0A. On transfer:
    - line_cnt++.
    - line_start advances one step; cur_char is loaded with the new line_start; char_idx=0.
    - Go to CHAR if en=1, else IDLE.
- Character arithmetic:
  - "Advance" means: LAST_CHAR wraps to FIRST_CHAR, otherwise +1.
  - Rotation period is R = LAST_CHAR-FIRST_CHAR+1 (95 by default).
- Disable (en=0):
  - en is sampled only after a transfer.
  - If en=0 after a CHAR or CR transfer, the block goes to IDLE but keeps state, char_idx, cur_char and line_start. Re-enabling resumes at the exact next byte; the line is not restarted.
  - A resume-state register holds CHAR/CR/LF while IDLE.
- Pacing:
  - pace_cnt clears on each transfer and saturates at CDIV-1.
  - With CDIV>1, valid for the next byte asserts only once pace_cnt==CDIV-1. Handshakes are therefore at least CDIV cycles apart.
  - With CDIV<=1, valid stays high across consecutive transfers (one byte per cycle when ready=1).
  - Stalls from ready=0 count toward the pacing interval.
- busy: high in CHAR/CR/LF, low in IDLE.
- line_cnt: wraps 16'hFFFF -> 0 without side effects.
- Reset mid-operation: asynchronous return to reset values; any pending valid drops immediately. After reset the pattern restarts at line 0, char FIRST_CHAR.
- Simultaneous en fall and ready during the last LF: the transfer completes, line_cnt increments, then the block enters IDLE with resume=CHAR at the new line_start.

Test Plan:
1. Defaults, ready=1, en=1 from reset: bytes 0x20..0x67 (72 bytes) then 0x0D, 0x0A. Line 2 runs 0x21..0x68 then CR LF. line_cnt=2 after the second LF.
2. Run 95 lines: line 94 starts 0x7E and its second char is 0x20. Line 95 starts 0x20, identical to line 0. line_cnt=95.
3. Backpressure: hold ready=0 for 5 cycles while valid=1 with data=0x25. Required: data and valid stable for all 5 cycles; exactly one transfer of 0x25 when ready rises; next byte is 0x26.
4. CDIV=4, ready=1: handshakes are exactly 4 cycles apart. Same check with ready low for 6 cycles: the next transfer occurs when ready rises, and the following transfer is 4 cycles later.
5. Drop en after the transfer of byte 10 of line 0 (0x29): valid=0, busy=0. Re-enable after 20 cycles: next byte is 0x2A and line_cnt is unchanged. Drop en during CR: resume outputs 0x0D.
6. Assert n_rst low mid-line (e.g. at data=0x40, valid=1): valid=0 immediately without a clock edge. After release, the first byte is 0x20 and line_cnt=0.

Source files
------------

// File: rtl/chargen_src_if.sv
// rtl/chargen_src_if.sv - byte stream handshake between chargen source and FIFO write side
interface chargen_src_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/chargen_src.sv
// rtl/chargen_src.sv - chargen rotating ASCII line generator with optional output pacing
module chargen_src #(
    parameter int          LINE_LEN   = 72,
    parameter logic [7:0]  FIRST_CHAR = 8'h20,
    parameter logic [7:0]  LAST_CHAR  = 8'h7E,
    parameter int          CDIV       = 0
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           en,
    chargen_src_if.master  m,
    output logic [15:0]    line_cnt,
    output logic           busy
);

    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  CHAR     = 2'd1;
    localparam logic [1:0]  CR       = 2'd2;
    localparam logic [1:0]  LF       = 2'd3;
    localparam logic [15:0] PACE_MAX = (CDIV > 1) ? 16'(CDIV - 1) : 16'd0;
    localparam logic [7:0]  LAST_IDX = 8'(LINE_LEN - 1);

    logic [1:0]  state, resume, pos, nxt_pos;
    logic [7:0]  cur_char, line_start, char_idx, data_c;
    logic [15:0] pace_cnt, pace_nxt;
    logic        valid_r, xfer, pace_ok;

    function automatic logic [7:0] advance(input logic [7:0] c);
        return (c == LAST_CHAR) ? FIRST_CHAR : c + 8'd1;
    endfunction

    // While idle, the byte position is remembered in resume so data still shows the next byte.
    assign pos     = (state == IDLE) ? resume : state;
    assign xfer    = valid_r && m.ready;
    assign busy    = (state != IDLE);
    assign m.valid = valid_r;
    assign m.data  = data_c;

    always_comb begin
        data_c  = cur_char;
        nxt_pos = pos;
        case (pos)
            CHAR:    nxt_pos = (char_idx == LAST_IDX) ? CR : CHAR;
            CR:      begin data_c = 8'h0D; nxt_pos = LF;   end
            LF:      begin data_c = 8'h0A; nxt_pos = CHAR; end
            default: nxt_pos = CHAR;
        endcase
    end

    // pace_nxt reaching PACE_MAX raises valid in the same edge, so handshakes land exactly CDIV apart.
    always_comb begin
        if (xfer)
            pace_nxt = 16'd0;
        else if (pace_cnt == PACE_MAX)
            pace_nxt = pace_cnt;
        else
            pace_nxt = pace_cnt + 16'd1;
        pace_ok = (CDIV <= 1) || (pace_nxt == PACE_MAX);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            resume     <= CHAR;
            cur_char   <= FIRST_CHAR;
            line_start <= FIRST_CHAR;
            char_idx   <= 8'd0;
            pace_cnt   <= 16'd0;
            line_cnt   <= 16'd0;
            valid_r    <= 1'b0;
        end else begin
            pace_cnt <= pace_nxt;
            if (state == IDLE) begin
                valid_r <= 1'b0;
                if (en)
                    state <= resume;
            end else if (xfer) begin
                case (state)
                    CHAR: begin
                        cur_char <= advance(cur_char);
                        if (char_idx != LAST_IDX)
                            char_idx <= char_idx + 8'd1;
                    end
                    LF: begin
                        line_cnt   <= line_cnt + 16'd1;
                        line_start <= advance(line_start);
                        cur_char   <= advance(line_start);
                        char_idx   <= 8'd0;
                    end
                    default: ;
                endcase
                resume <= nxt_pos;
                if (en) begin
                    state   <= nxt_pos;
                    valid_r <= pace_ok;
                end else begin
                    state   <= IDLE;
                    valid_r <= 1'b0;
                end
            end else if (!valid_r) begin
                valid_r <= pace_ok;
            end
        end
    end

endmodule

// File: tb/tb_chargen_src.sv
// tb/tb_chargen_src.sv - directed vector bench for chargen_src
module tb_chargen_src;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        en0, en4;
    logic [15:0] line_cnt0, line_cnt4;
    logic        busy0, busy4;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic [7:0]  log0[$];
    logic [7:0]  log4[$];
    int          t4[$];

    chargen_src_if bus0();
    chargen_src_if bus4();

    chargen_src u0 (.clk(clk), .n_rst(n_rst), .en(en0), .m(bus0.master),
                    .line_cnt(line_cnt0), .busy(busy0));
    chargen_src #(.CDIV(4)) u4 (.clk(clk), .n_rst(n_rst), .en(en4), .m(bus4.master),
                    .line_cnt(line_cnt4), .busy(busy4));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus0.valid && bus0.ready) log0.push_back(bus0.data);
        if (bus4.valid && bus4.ready) begin
            log4.push_back(bus4.data);
            t4.push_back(cyc);
        end
    end

    typedef struct {
        int         pos;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic timeout(input string nm);
        total_cnt++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Waits at negedges until u0 presents byte b with valid high.
    task automatic wait_byte(input logic [7:0] b, input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus0.valid && bus0.data == b) return;
        end
        timeout(nm);
    endtask

    task automatic wait_log0(input int n, input string nm);
        for (int i = 0; i < 50; i++) begin
            if (log0.size() >= n) return;
            @(negedge clk);
        end
        timeout(nm);
    endtask

    initial begin
        int errs, n, raise, lc_l2;
        logic [7:0] e;
        logic got_l2;

        tbl[0]  = '{0,             8'h20};
        tbl[1]  = '{71,            8'h67};
        tbl[2]  = '{72,            8'h0D};
        tbl[3]  = '{73,            8'h0A};
        tbl[4]  = '{74,            8'h21};
        tbl[5]  = '{74 + 71,       8'h68};
        tbl[6]  = '{74 + 72,       8'h0D};
        tbl[7]  = '{74 + 73,       8'h0A};
        tbl[8]  = '{94 * 74,       8'h7E};
        tbl[9]  = '{94 * 74 + 1,   8'h20};
        tbl[10] = '{95 * 74,       8'h20};

        n_rst = 1'b0; en0 = 1'b0; en4 = 1'b0; bus0.ready = 1'b0; bus4.ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(bus0.data), 32'h20);
        chk("rst_valid", 32'(bus0.valid), 0);
        chk("rst_busy",  32'(busy0), 0);
        chk("rst_lcnt",  32'(line_cnt0), 0);
        chk("rst_valid4", 32'(bus4.valid), 0);
        n_rst = 1'b1;

        // Pacing with CDIV=4
        @(negedge clk);
        en4 = 1'b1; bus4.ready = 1'b1;
        for (int i = 0; i < 100 && t4.size() < 6; i++) @(negedge clk);
        if (t4.size() < 6) timeout("pace_run");
        else begin
            errs = 0;
            for (int i = 1; i < 6; i++) if (t4[i] - t4[i-1] != 4) errs++;
            chk("pace_gap4", 32'(errs), 0);
            errs = 0;
            for (int i = 0; i < 6; i++) if (log4[i] != 8'(32 + i)) errs++;
            chk("pace_data", 32'(errs), 0);
        end
        for (int i = 0; i < 20 && !bus4.valid; i++) @(negedge clk);
        bus4.ready = 1'b0;
        n = t4.size();
        errs = 0;
        repeat (6) begin
            @(negedge clk);
            if (!bus4.valid) errs++;
        end
        chk("pace_stall_valid", 32'(errs), 0);
        chk("pace_stall_noxfer", 32'(t4.size()), 32'(n));
        bus4.ready = 1'b1;
        raise = cyc;
        for (int i = 0; i < 30 && t4.size() < n + 2; i++) @(negedge clk);
        if (t4.size() < n + 2) timeout("pace_after_stall");
        else begin
            chk("pace_first_after_stall", 32'(t4[n] - raise), 0);
            chk("pace_next_after_stall", 32'(t4[n+1] - t4[n]), 4);
        end
        en4 = 1'b0;

        // Free run of 95 lines plus one byte
        en0 = 1'b1; bus0.ready = 1'b1;
        got_l2 = 1'b0; lc_l2 = 0;
        for (int i = 0; i < 8000 && log0.size() < 95 * 74 + 1; i++) begin
            @(negedge clk);
            if (log0.size() == 148 && !got_l2) begin
                got_l2 = 1'b1;
                lc_l2 = int'(line_cnt0);
            end
        end
        bus0.ready = 1'b0;
        if (log0.size() < 95 * 74 + 1) timeout("run95");
        chk("lcnt_after_l2", 32'(lc_l2), 2);
        chk("lcnt_95", 32'(line_cnt0), 95);
        for (int i = 0; i < 11; i++)
            if (log0.size() > tbl[i].pos) chk($sformatf("tbl_%0d", tbl[i].pos), 32'(log0[tbl[i].pos]), 32'(tbl[i].exp));
            else timeout($sformatf("tbl_%0d", tbl[i].pos));
        errs = 0;
        for (int i = 0; i < log0.size(); i++) begin
            if (i % 74 < 72) e = 8'(32 + ((i / 74) + (i % 74)) % 95);
            else e = (i % 74 == 72) ? 8'h0D : 8'h0A;
            if (log0[i] != e) errs++;
        end
        chk("stream_model", 32'(errs), 0);

        // Backpressure at 0x25
        bus0.ready = 1'b1;
        wait_byte(8'h25, "reach_25");
        bus0.ready = 1'b0;
        n = log0.size();
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (!bus0.valid || bus0.data != 8'h25) errs++;
        end
        chk("bp_stable", 32'(errs), 0);
        chk("bp_noxfer", 32'(log0.size()), 32'(n));
        bus0.ready = 1'b1;
        @(negedge clk);
        bus0.ready = 1'b0;
        chk("bp_one_xfer", 32'(log0.size()), 32'(n + 1));
        if (log0.size() > n) chk("bp_xfer_byte", 32'(log0[n]), 32'h25);
        chk("bp_next_byte", 32'(bus0.data), 32'h26);

        // Asynchronous reset mid-line
        bus0.ready = 1'b1;
        wait_byte(8'h40, "reach_40");
        bus0.ready = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus0.valid), 0);
        chk("arst_busy", 32'(busy0), 0);
        chk("arst_lcnt", 32'(line_cnt0), 0);
        @(negedge clk);
        n_rst = 1'b1;
        log0.delete();
        bus0.ready = 1'b1;
        wait_log0(1, "arst_first");
        if (log0.size() > 0) chk("arst_first_byte", 32'(log0[0]), 32'h20);

        // Disable after 0x29, resume at 0x2A
        wait_byte(8'h29, "reach_29");
        en0 = 1'b0;
        @(negedge clk);
        chk("dis_valid", 32'(bus0.valid), 0);
        chk("dis_busy", 32'(busy0), 0);
        chk("dis_count", 32'(log0.size()), 10);
        repeat (20) @(negedge clk);
        chk("dis_hold", 32'(log0.size()), 10);
        en0 = 1'b1;
        wait_log0(11, "resume_2a");
        if (log0.size() > 10) chk("resume_byte", 32'(log0[10]), 32'h2A);
        chk("resume_lcnt", 32'(line_cnt0), 0);

        // Disable before CR, then drop en together with the LF transfer
        wait_byte(8'h67, "reach_67");
        en0 = 1'b0;
        @(negedge clk);
        chk("cr_idle_data", 32'(bus0.data), 32'h0D);
        chk("cr_idle_valid", 32'(bus0.valid), 0);
        repeat (5) @(negedge clk);
        en0 = 1'b1;
        wait_byte(8'h0A, "reach_lf");
        en0 = 1'b0;
        @(negedge clk);
        n = log0.size();
        if (n >= 2) begin
            chk("cr_resume_byte", 32'(log0[n-2]), 32'h0D);
            chk("lf_last_byte", 32'(log0[n-1]), 32'h0A);
        end else timeout("cr_lf_log");
        chk("lf_lcnt", 32'(line_cnt0), 1);
        chk("lf_idle_busy", 32'(busy0), 0);
        chk("lf_idle_data", 32'(bus0.data), 32'h21);
        en0 = 1'b1;
        wait_log0(n + 1, "line1_start");
        if (log0.size() > n) chk("line1_first", 32'(log0[n]), 32'h21);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
